// File: rtl/ctrl_program_loader_if.sv
// Beat stream from the host into the program loader.
// Beat moves when s_valid and s_ready are both high.
interface ctrl_program_loader_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/ctrl_program_loader.sv
// Packs host beats into control words, writes them into the tester BRAM,
// then starts the tester and reports run length and error status.
module ctrl_program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int CTRL_WIDTH = 72,
    parameter int IN_WIDTH = 32,
    parameter int CNT_WIDTH = 32,
    parameter int ARM_TIMEOUT = 16,
    parameter logic [CNT_WIDTH-1:0] MAX_RUN_CYCLES = '1
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    ctrl_program_loader_if.slave  s_if,
    input  logic                  cmd_load,
    input  logic                  cmd_run,
    input  logic                  cmd_clear,
    output logic [ADDR_WIDTH-1:0] bram_ZYNQ_INST_addr,
    output logic [CTRL_WIDTH-1:0] bram_ZYNQ_INST_din,
    output logic                  bram_ZYNQ_INST_en,
    output logic                  bram_ZYNQ_INST_we,
    output logic                  START,
    input  logic                  COMPLETED,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            error,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [CNT_WIDTH-1:0]  cycle_count
);
    localparam int BEATS = (CTRL_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
    localparam int BIW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ATW = $clog2(ARM_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH =
        (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WC_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] CC_ONE = CNT_WIDTH'(1);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);
    localparam logic [BIW-1:0] BI_ONE = BIW'(1);
    localparam logic [ATW-1:0] ARM_LAST = ATW'(ARM_TIMEOUT - 1);
    localparam logic [ATW-1:0] AT_ONE = ATW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOADED,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q;
    logic [BIW-1:0]        bidx_q;
    logic [CTRL_WIDTH-1:0] asm_q;
    logic                  last_q;
    logic                  term_q;
    logic                  en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CTRL_WIDTH-1:0] din_q;
    logic                  start_q;
    logic [1:0]            err_q;
    logic [ADDR_WIDTH:0]   wcnt_q;
    logic [CNT_WIDTH-1:0]  cyc_q;
    logic [ATW-1:0]        arm_q;

    logic [CTRL_WIDTH-1:0] word_d;
    logic [ADDR_WIDTH:0]   fill_d;
    logic                  beat;
    logic                  load_go;
    logic                  run_go;

    assign s_if.s_ready = (state_q == S_LOAD) && !last_q;
    assign beat = s_if.s_valid && s_if.s_ready;

    // A word already latched for writing counts as stored.
    assign fill_d = wcnt_q + {{ADDR_WIDTH{1'b0}}, en_q};

    assign load_go = cmd_load &&
        (state_q inside {S_IDLE, S_LOADED, S_DONE});
    assign run_go = cmd_run &&
        (state_q inside {S_LOADED, S_DONE});

    always_comb begin
        word_d = asm_q;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (i / IN_WIDTH == int'(bidx_q))
                word_d[i] = s_if.s_data[i % IN_WIDTH];
        end
    end

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            state_q <= S_IDLE;
            bidx_q  <= '0;
            asm_q   <= '0;
            last_q  <= 1'b0;
            term_q  <= 1'b0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 2'd0;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            arm_q   <= '0;
        end else begin
            en_q <= 1'b0;
            if (en_q)
                wcnt_q <= wcnt_q + WC_ONE;
            if (load_go) begin
                state_q <= S_LOAD;
                wcnt_q  <= '0;
                bidx_q  <= '0;
                asm_q   <= '0;
                last_q  <= 1'b0;
            end else if (run_go) begin
                state_q <= S_ARM;
                start_q <= 1'b1;
                cyc_q   <= '0;
                arm_q   <= '0;
            end else begin
                unique case (state_q)
                    S_LOAD: begin
                        if (last_q) begin
                            last_q <= 1'b0;
                            if (term_q) begin
                                state_q <= S_LOADED;
                            end else begin
                                state_q <= S_ERR;
                                err_q   <= 2'd2;
                            end
                        end else if (beat) begin
                            if (fill_d == DEPTH) begin
                                state_q <= S_ERR;
                                err_q   <= 2'd1;
                            end else if (bidx_q == LAST_BEAT ||
                                         s_if.s_last) begin
                                en_q   <= 1'b1;
                                addr_q <= fill_d[ADDR_WIDTH-1:0];
                                din_q  <= word_d;
                                term_q <= word_d[0];
                                last_q <= s_if.s_last;
                                asm_q  <= '0;
                                bidx_q <= '0;
                            end else begin
                                asm_q  <= word_d;
                                bidx_q <= bidx_q + BI_ONE;
                            end
                        end
                    end
                    S_ARM: begin
                        if (!COMPLETED) begin
                            state_q <= S_RUN;
                            cyc_q   <= CC_ONE;
                        end else if (arm_q == ARM_LAST) begin
                            state_q <= S_ERR;
                            err_q   <= 2'd3;
                            start_q <= 1'b0;
                        end else begin
                            arm_q <= arm_q + AT_ONE;
                        end
                    end
                    S_RUN: begin
                        if (COMPLETED) begin
                            state_q <= S_DONE;
                            start_q <= 1'b0;
                        end else begin
                            cyc_q <= cyc_q + CC_ONE;
                            if (cyc_q + CC_ONE == MAX_RUN_CYCLES) begin
                                state_q <= S_ERR;
                                err_q   <= 2'd3;
                                start_q <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        if (cmd_clear)
                            state_q <= S_LOADED;
                    end
                    S_ERR: begin
                        if (cmd_clear) begin
                            state_q <= S_IDLE;
                            err_q   <= 2'd0;
                            wcnt_q  <= '0;
                            cyc_q   <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bram_ZYNQ_INST_addr = addr_q;
    assign bram_ZYNQ_INST_din  = din_q;
    assign bram_ZYNQ_INST_en   = en_q;
    assign bram_ZYNQ_INST_we   = en_q;
    assign START       = start_q;
    assign busy        = state_q inside {S_LOAD, S_ARM, S_RUN};
    assign done        = (state_q == S_DONE);
    assign error       = err_q;
    assign word_count  = wcnt_q;
    assign cycle_count = cyc_q;
endmodule

// File: tb/tb_ctrl_program_loader.sv
// Randomized bench for ctrl_program_loader against a word-level model
// of the load, run and error behaviour.
module tb_ctrl_program_loader;
    localparam int AW = 12;
    localparam int CW = 72;
    localparam int IW = 32;
    localparam int NW = 32;
    localparam int BEATS = (CW + IW - 1) / IW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_load, cmd_run, cmd_clear;
    logic [AW-1:0] addr;
    logic [CW-1:0] din;
    logic          en, we, start, completed, busy, done;
    logic [1:0]    error;
    logic [AW:0]   wcnt;
    logic [NW-1:0] ccnt;

    ctrl_program_loader_if #(.IN_WIDTH(IW)) sif ();

    ctrl_program_loader dut (
        .CLK_100(clk),
        .RST(rst),
        .s_if(sif.slave),
        .cmd_load(cmd_load),
        .cmd_run(cmd_run),
        .cmd_clear(cmd_clear),
        .bram_ZYNQ_INST_addr(addr),
        .bram_ZYNQ_INST_din(din),
        .bram_ZYNQ_INST_en(en),
        .bram_ZYNQ_INST_we(we),
        .START(start),
        .COMPLETED(completed),
        .busy(busy),
        .done(done),
        .error(error),
        .word_count(wcnt),
        .cycle_count(ccnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] mon_a[$];
    logic [CW-1:0] mon_d[$];
    int collide = 0;

    always @(negedge clk) begin
        if (en) begin
            mon_a.push_back(addr);
            mon_d.push_back(din);
            if (!we || start) collide++;
        end
    end

    logic [IW-1:0] pb[$];
    bit            pl[$];
    logic [CW-1:0] ew[$];

    function automatic void build(input int nwords, input int lastb,
                                  input bit term, input bit with_last);
        int nb;
        logic [IW-1:0] d;
        pb.delete();
        pl.delete();
        for (int w = 0; w < nwords; w++) begin
            nb = (with_last && w == nwords - 1) ? lastb : BEATS;
            for (int k = 0; k < nb; k++) begin
                d = $urandom;
                if (with_last && w == nwords - 1 && k == 0) d[0] = term;
                pb.push_back(d);
                pl.push_back(with_last && w == nwords - 1 && k == nb - 1);
            end
        end
    endfunction

    // Words are the beats concatenated low-first, cut at BEATS or s_last.
    function automatic void model();
        logic [BEATS*IW-1:0] cur;
        int k;
        cur = '0;
        k = 0;
        ew.delete();
        foreach (pb[i]) begin
            cur = cur | ((BEATS*IW)'(pb[i]) << (IW * k));
            k++;
            if (k == BEATS || pl[i]) begin
                ew.push_back(cur[CW-1:0]);
                cur = '0;
                k = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit l, input bit r, input bit c);
        cmd_load = l;
        cmd_run = r;
        cmd_clear = c;
        tick();
        cmd_load = 1'b0;
        cmd_run = 1'b0;
        cmd_clear = 1'b0;
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input bit l);
        bit ok;
        ok = 1'b0;
        sif.s_data = d;
        sif.s_valid = 1'b1;
        sif.s_last = l;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (sif.s_ready) ok = 1'b1;
            tick();
        end
        if (!ok) chk("beat_accept", 0, 1);
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
    endtask

    task automatic send_prog(input bit gaps);
        foreach (pb[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            send_beat(pb[i], pl[i]);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 20 && busy; t++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic check_writes();
        int n;
        n = (mon_a.size() < ew.size()) ? mon_a.size() : ew.size();
        chk("wr_count", mon_a.size(), ew.size());
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", mon_a[i], i);
            chk("wr_data", mon_d[i], ew[i]);
        end
        mon_a.delete();
        mon_d.delete();
    endtask

    task automatic load_prog(input int nw, input int lb,
                             input bit term, input bit gaps);
        build(nw, lb, term, 1'b1);
        model();
        send_prog(gaps);
        wait_idle("load_idle");
        chk("load_err", error, term ? 2'd0 : 2'd2);
        chk("load_wcnt", wcnt, ew.size());
        check_writes();
    endtask

    // Tester model: d idle cycles after START, then COMPLETED low for n.
    task automatic run_prog(input int n, input int d);
        pulse(1'b0, 1'b1, 1'b0);
        chk("arm_start", start, 1);
        repeat (d) tick();
        completed = 1'b0;
        repeat (n) tick();
        chk("run_start", {start, busy}, 2'b11);
        completed = 1'b1;
        tick();
        chk("run_done", {done, start, busy}, 3'b100);
        chk("run_cycles", ccnt, n);
    endtask

    initial begin
        rst = 1'b1;
        cmd_load = 1'b0;
        cmd_run = 1'b0;
        cmd_clear = 1'b0;
        completed = 1'b1;
        sif.s_data = '0;
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_flags",
            {start, busy, done, error, en, we, sif.s_ready}, 0);
        chk("rst_counts", {wcnt, ccnt}, 0);

        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_run_ignored", {start, busy}, 0);

        pulse(1'b1, 1'b0, 1'b0);
        chk("load_ready", {sif.s_ready, busy, start}, 3'b110);
        build(2, 3, 1'b1, 1'b1);
        model();
        send_prog(1'b0);
        wait_idle("t1_idle");
        chk("t1_wcnt", wcnt, 2);
        chk("t1_word0", mon_d.size() > 0 ? mon_d[0] : '0,
            {pb[2][7:0], pb[1], pb[0]});
        check_writes();

        run_prog(100, 2);
        run_prog($urandom_range(1, 60), $urandom_range(0, 10));
        pulse(1'b0, 1'b0, 1'b1);
        chk("clear_loaded", {done, busy, error}, 0);
        run_prog($urandom_range(1, 40), $urandom_range(0, 15));

        for (int it = 0; it < 4; it++) begin
            pulse(1'b1, 1'b0, 1'b0);
            load_prog($urandom_range(1, 20), $urandom_range(1, 3),
                      1'b1, 1'b1);
            run_prog($urandom_range(1, 50), $urandom_range(0, 8));
        end

        pulse(1'b1, 1'b1, 1'b0);
        chk("t6_load_wins", {busy, sif.s_ready, start}, 3'b110);
        chk("t6_wcnt", wcnt, 0);
        load_prog(3, 2, 1'b1, 1'b1);

        pulse(1'b1, 1'b0, 1'b0);
        load_prog(4, 1, 1'b0, 1'b1);
        chk("t3_ready", sif.s_ready, 0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t3_err_holds", {error, busy}, 3'b100);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t3_clear", {error, busy, wcnt, ccnt}, 0);

        pulse(1'b1, 1'b0, 1'b0);
        load_prog(2, 3, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (15) tick();
        chk("arm_wait", {start, error}, 3'b100);
        tick();
        chk("arm_timeout", {start, busy, error}, 4'b0011);
        pulse(1'b0, 1'b0, 1'b1);
        chk("arm_clear", error, 0);

        pulse(1'b1, 1'b0, 1'b0);
        build(4096, 3, 1'b0, 1'b0);
        model();
        pb.push_back($urandom);
        pl.push_back(1'b0);
        send_prog(1'b0);
        chk("ovf_err", error, 1);
        chk("ovf_ready", sif.s_ready, 0);
        chk("ovf_wcnt", wcnt, 4096);
        check_writes();
        pulse(1'b0, 1'b0, 1'b1);

        pulse(1'b1, 1'b0, 1'b0);
        load_prog(1, 2, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        completed = 1'b0;
        repeat (5) tick();
        chk("rst_run_cycles", ccnt, 5);
        rst = 1'b1;
        tick();
        chk("rst_run_flags",
            {start, busy, done, error, en, we, sif.s_ready}, 0);
        chk("rst_run_counts", {wcnt, ccnt, addr}, 0);
        chk("rst_run_din", din, 0);
        rst = 1'b0;
        completed = 1'b1;
        tick();

        chk("bram_vs_start", collide, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
